// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle ALU with the base operation set plus the RV32M
// multiply/divide/remainder group.
//
// Base operations (Operation[4] = 0) and the reserved M codes 11xxx finish in
// one cycle. MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU run for DATA_WIDTH cycles
// on an unsigned shift-add / restoring-divide datapath. Signs are removed when
// the operands are captured and put back when the result register is loaded.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (Operation, SrcA, SrcB)
//   out_valid / out_ready result handshake (ALUResult, Zero)
//   busy                  iterative operation in progress
module alu_muldiv #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero,
  output logic                     busy
);

  localparam int              CW   = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Two's-complement negate when n is set.
  function automatic logic [DATA_WIDTH-1:0] neg_if(input logic [DATA_WIDTH-1:0] x,
                                                   input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*DATA_WIDTH-1:0] neg2_if(input logic [2*DATA_WIDTH-1:0] x,
                                                      input logic n);
    return n ? -x : x;
  endfunction

  // Single-cycle base operation set.
  function automatic logic [DATA_WIDTH-1:0] base_alu(input logic [3:0]            op,
                                                     input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    logic        [CW-1:0]         sh;
    logic        [DATA_WIDTH-1:0] r;
    sa = a;
    sb = b;
    sh = b[CW-1:0];
    r  = '0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a ^ b;
      4'b0010: r = a + b;
      4'b0011: r = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
      4'b0100: r = {{(DATA_WIDTH-1){1'b0}}, (a != b)};
      4'b0101: r = a | b;
      4'b0110: r = a << sh;
      4'b0111: r = sa >>> sh;
      4'b1000: r = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
      4'b1010: r = a - b;
      4'b1011: r = a + b;
      4'b1100: r = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
      4'b1101: r = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
      4'b1110: r = a >> sh;
      4'b1111: r = {{(DATA_WIDTH-1){1'b0}}, (sa >= sb)};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [1:0]              state;
  logic [CW-1:0]           count;
  logic                    accept;
  logic                    is_iter;

  logic [2:0]              mop_p0;
  logic                    a_neg_p0;
  logic                    b_neg_p0;
  logic                    b_zero_p0;
  logic [DATA_WIDTH-1:0]   opnd_p0;
  logic [2*DATA_WIDTH-1:0] acc_p0;

  logic [DATA_WIDTH-1:0]   result_p1;
  logic                    zero_p1;

  assign in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_iter   = Operation[4] && !Operation[3];
  assign busy      = (state == ST_BUSY);
  assign out_valid = (state == ST_DONE);
  assign ALUResult = result_p1;
  assign Zero      = zero_p1;

  // ---- capture: operand signedness and magnitudes ----
  logic                  sgn_a;
  logic                  sgn_b;
  logic                  a_neg_in;
  logic                  b_neg_in;
  logic [DATA_WIDTH-1:0] mag_a_in;
  logic [DATA_WIDTH-1:0] mag_b_in;
  logic [DATA_WIDTH-1:0] imm_res;

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (Operation[2:0])
      3'b001:         begin sgn_a = 1'b1; sgn_b = 1'b1; end // MULH
      3'b010:         sgn_a = 1'b1;                         // MULHSU
      3'b100, 3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; end // DIV, REM
      default:        ;
    endcase
    a_neg_in = sgn_a & SrcA[DATA_WIDTH-1];
    b_neg_in = sgn_b & SrcB[DATA_WIDTH-1];
    mag_a_in = neg_if(SrcA, a_neg_in);
    mag_b_in = neg_if(SrcB, b_neg_in);
    // Reserved M codes 11xxx complete immediately with zero.
    imm_res  = Operation[4] ? '0 : base_alu(Operation[3:0], SrcA, SrcB);
  end

  // ---- iteration: one multiply or divide bit per cycle ----
  // acc_p0 holds {high, low}: for multiply {partial product, multiplier},
  // for divide {partial remainder, dividend/quotient}. opnd_p0 is the
  // multiplicand or the divisor.
  logic [DATA_WIDTH:0]     mul_sum;
  logic [DATA_WIDTH:0]     rem_sh;
  logic [DATA_WIDTH:0]     diff;
  logic [2*DATA_WIDTH-1:0] mul_next;
  logic [2*DATA_WIDTH-1:0] div_next;
  logic [2*DATA_WIDTH-1:0] acc_next;

  always_comb begin
    mul_sum  = {1'b0, acc_p0[2*DATA_WIDTH-1:DATA_WIDTH]}
             + (acc_p0[0] ? {1'b0, opnd_p0} : '0);
    mul_next = {mul_sum, acc_p0[DATA_WIDTH-1:1]};
    rem_sh   = {acc_p0[2*DATA_WIDTH-1:DATA_WIDTH], acc_p0[DATA_WIDTH-1]};
    diff     = rem_sh - {1'b0, opnd_p0};
    // A borrow means the divisor does not fit: restore and shift in a 0.
    if (diff[DATA_WIDTH])
      div_next = {rem_sh[DATA_WIDTH-1:0], acc_p0[DATA_WIDTH-2:0], 1'b0};
    else
      div_next = {diff[DATA_WIDTH-1:0], acc_p0[DATA_WIDTH-2:0], 1'b1};
    acc_next = mop_p0[2] ? div_next : mul_next;
  end

  // ---- result: sign correction of the final iteration ----
  logic [2*DATA_WIDTH-1:0] prod_s;
  logic [DATA_WIDTH-1:0]   quo;
  logic [DATA_WIDTH-1:0]   rem;
  logic [DATA_WIDTH-1:0]   m_result;

  always_comb begin
    prod_s   = neg2_if(acc_next, a_neg_p0 ^ b_neg_p0);
    quo      = acc_next[DATA_WIDTH-1:0];
    rem      = acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
    m_result = '0;
    case (mop_p0)
      3'b000:                 m_result = prod_s[DATA_WIDTH-1:0];
      3'b001, 3'b010, 3'b011: m_result = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
      // Divide by zero yields all ones regardless of the dividend sign.
      3'b100, 3'b101:         m_result = b_zero_p0 ? '1 : neg_if(quo, a_neg_p0 ^ b_neg_p0);
      default:                m_result = neg_if(rem, a_neg_p0);
    endcase
  end

  // ---- control and result register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      result_p1 <= '0;
      zero_p1   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            count <= '0;
            if (is_iter) begin
              state <= ST_BUSY;
            end else begin
              state     <= ST_DONE;
              result_p1 <= imm_res;
              zero_p1   <= (imm_res == '0);
            end
          end else if (state == ST_DONE && out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          count <= count + CW'(1);
          if (count == LAST) begin
            state     <= ST_DONE;
            result_p1 <= m_result;
            zero_p1   <= (m_result == '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- iterative datapath registers ----
  always_ff @(posedge clk) begin
    if (accept && is_iter) begin
      mop_p0    <= Operation[2:0];
      a_neg_p0  <= a_neg_in;
      b_neg_p0  <= b_neg_in;
      b_zero_p0 <= (SrcB == '0);
      opnd_p0   <= Operation[2] ? mag_b_in : mag_a_in;
      acc_p0    <= {{DATA_WIDTH{1'b0}}, (Operation[2] ? mag_a_in : mag_b_in)};
    end else if (state == ST_BUSY) begin
      acc_p0 <= acc_next;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (DATA_WIDTH = 32): directed vectors push
// their expected result into a queue; a monitor pops and compares on every
// accepted output.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  Operation = '0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  alu_muldiv #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issue one request, then verify its latency (and busy length for M ops).
  // Called at posedge+1; returns at posedge+1 of the first out_valid cycle.
  task automatic run_op(input string nm, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int waited;
    int k;
    int bc;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    waited    = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: in_ready never rose within 100 cycles", nm);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    Operation = 5'($urandom);
    SrcA      = $urandom;
    SrcB      = $urandom;
    if (op[4] && !op[3]) begin
      k  = 1;
      bc = 0;
      while (!out_valid && k < 40) begin
        if (busy) bc++;
        @(posedge clk); #1;
        k++;
      end
      check({nm, "_latency"}, 32'(k), 32'd33);
      check({nm, "_busy_cycles"}, 32'(bc), 32'd32);
    end else begin
      check({nm, "_latency"}, 32'(out_valid), 32'd1);
    end
  endtask

  // Monitor: compares every result as it is handed over.
  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got %h, expected no output", ALUResult);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          check(n, ALUResult, e);
          check({n, "_zero"}, 32'(Zero), 32'(e == 32'd0));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    // Reset values
    reset     = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    ALUResult,      32'd0);
    check("rst_zero",      32'(Zero),      32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Base group, issued back-to-back
    run_op("add",  5'b00010, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0002);
    check("add_in_ready_next", 32'(in_ready), 32'd1);
    run_op("slt",  5'b01100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    run_op("sra",  5'b00111, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    run_op("sub",  5'b01010, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE);
    run_op("eq",   5'b01000, 32'h0000_0007, 32'h0000_0007, 32'h0000_0001);
    run_op("xor",  5'b00001, 32'hFF00_FF00, 32'hFFFF_FFFF, 32'h00FF_00FF);
    run_op("srl",  5'b01110, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
    run_op("ge",   5'b01111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    run_op("sll",  5'b00110, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000);
    run_op("op9",  5'b01001, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000);
    run_op("m_rsv",5'b11000, 32'h0000_0009, 32'h0000_0003, 32'h0000_0000);

    // M group
    run_op("mulh",   5'b10001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF);
    run_op("mul",    5'b10000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA);
    run_op("mulhu",  5'b10011, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002);
    run_op("mulhsu", 5'b10010, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF);
    run_op("div",    5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    run_op("rem",    5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    run_op("divu",   5'b10101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E);
    run_op("remu",   5'b10111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002);
    run_op("divu0",  5'b10101, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF);
    run_op("remu0",  5'b10111, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007);
    run_op("div_ovf",5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // Let the last result go before withholding out_ready
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op("mul_hold", 5'b10000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA);
    for (int i = 0; i < 5; i++) begin
      check("hold_result",    ALUResult,      32'hFFFF_FFFA);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;

    // DIVU aborted by reset in its 10th cycle
    Operation = 5'b10101;
    SrcA      = 32'h0000_0064;
    SrcB      = 32'h0000_0007;
    in_valid  = 1'b1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result",    ALUResult,      32'd0);
    check("abort_zero",      32'(Zero),      32'd1);
    check("abort_in_ready2", 32'(in_ready),  32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("abort_never_valid", 32'(seen), 32'd0);

    run_op("add_after", 5'b00010, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised multi-cycle successor to the core's combinational ALU. It keeps the full base operation set and adds the RV32M multiply/divide/remainder group, computed by a DATA_WIDTH-step iterative datapath. Operands and results move through valid/ready handshakes, so the execute stage can stall on long operations.

## Interface
- DATA_WIDTH, 32: operand and result width. Must be ≥ 4 and a power of two.
- OPCODE_LENGTH, 5: operation code width. Bit 4 selects the M-extension group.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- Operation  in  OPCODE_LENGTH  operation code.
- SrcA  in  DATA_WIDTH  operand A (dividend / multiplicand).
- SrcB  in  DATA_WIDTH  operand B (divisor / multiplier / shift amount).
- out_valid  out  1  ALUResult valid.
- out_ready  in  1  consumer accepts the result.
- ALUResult  out  DATA_WIDTH  registered result.
- Zero  out  1  ALUResult == 0, registered alongside ALUResult.
- busy  out  1  iterative operation in progress.

## Operation
- Request transfer occurs when in_valid && in_ready. Operation, SrcA and SrcB are captured in that cycle and ignored at all other times.
- Base group (bit 4 = 0), single-cycle, encodings:
  - 0000 AND, 0001 XOR, 0010 ADD, 0011 SLTI, 0100 NE, 0101 OR
  - 0110 SLL, 0111 SRA, 1000 EQ, 1010 SUB, 1011 ADD
  - 1100 SLT, 1101 LT, 1110 SRL, 1111 GE
  - 1001 returns 0.
- Base-group rules:
  - SLTI, SLT, LT and GE are signed two's-complement compares.
  - Shifts use SrcB[log2(DATA_WIDTH)-1:0] only. SRA sign-fills.
  - Compare ops return 1 or 0, zero-extended.
- M group (bit 4 = 1), iterative, encodings:
  - 10000 MUL (low half)
  - 10001 MULH (signed×signed, high half)
  - 10010 MULHSU (signed A × unsigned B, high half)
  - 10011 MULHU (unsigned high half)
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU
  - 11000–11111 return 0 in a single cycle.
- M-group arithmetic:
  - Signed operands are converted to magnitudes at capture.
  - Unsigned shift-add multiply or restoring divide runs, one bit per cycle, for DATA_WIDTH cycles.
  - The result sign is applied when the result register is loaded.
  - Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
- Divide by zero: DIV/DIVU return all ones; REM/REMU return SrcA. Still takes the full iteration count, with no early exit.
- Signed overflow (A = −2^(W−1), B = −1): DIV returns −2^(W−1); REM returns 0.
- State machine:
  - IDLE: on accept of a base op, go to DONE; on accept of an M op, go to BUSY with count = 0.
  - BUSY: count increments each cycle. When count == DATA_WIDTH−1, load the result and go to DONE.
  - DONE: on out_ready, go to IDLE, or take the new request if one is accepted the same cycle.
- in_ready = (state == IDLE) || (state == DONE && out_ready). This is a combinational path from out_ready.
- busy = (state == BUSY).

## Timing
- Reset values (state → IDLE, count cleared):
  - out_valid = 0, ALUResult = 0, Zero = 1, busy = 0
  - in_ready = 1 in the cycle after reset deasserts.
- Latency, counted from an accept in cycle N:
  - Base op: out_valid from cycle N+1.
  - M op: busy in cycles N+1 … N+DATA_WIDTH; out_valid from cycle N+DATA_WIDTH+1.
- out_valid, ALUResult and Zero stay stable until the cycle in which out_valid && out_ready.
- Back-to-back: if a result is consumed and a new request accepted in the same cycle, the new result follows with the normal latency. No bubble for base ops.
- in_ready = 0 throughout BUSY. in_valid is ignored there.
- reset asserted in any state, including mid-BUSY: the next cycle is IDLE with reset values. The partial result is discarded and never presented.
- Zero is computed from the final, sign-corrected result.

## Test plan
- Reset, then ADD 0x00000005 + 0xFFFFFFFD with out_ready = 1 → out_valid in cycle N+1, ALUResult = 0x00000002, Zero = 0. Next cycle in_ready = 1.
- SLT 0xFFFFFFFF, 0x00000001 → 1. SRA 0x80000000 by 0x24 → 0xF8000000 (shift amount 4).
- MULH 0xFFFFFFFE × 0x00000003 → 0xFFFFFFFF; MUL of the same operands → 0xFFFFFFFA. Each has out_valid first high in cycle N+33, and busy high for exactly 32 cycles.
- DIV 0xFFFFFFF9 / 0x00000002 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
- Boundary divides:
  - DIVU 7 / 0 → 0xFFFFFFFF; REMU → 7.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Hold out_ready = 0 for 5 cycles after a MUL result → ALUResult stable, in_ready = 0. Then assert reset during cycle 10 of a following DIVU → out_valid never rises for it, and the next ADD returns its correct result.
